// File: rtl/btn_cond_if.sv
// Button conditioner signal bundle: raw active-low buttons in, debounced level and pulses out.
// The master modport is the side that drives the buttons; the slave modport is the conditioner.
interface btn_cond_if #(
    parameter int N = 3
);
    logic [N-1:0] btn_i;
    logic [N-1:0] level_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;

    modport master (
        output btn_i,
        input  level_o,
        input  press_o,
        input  release_o
    );

    modport slave (
        input  btn_i,
        output level_o,
        output press_o,
        output release_o
    );
endinterface

// File: rtl/btn_cond.sv
// Per-channel button synchronizer, debouncer and press/release pulse generator.
// Optional auto-repeat of press pulses while held is enabled by defining BTN_REPEAT_EN.
module btn_cond #(
    parameter int N       = 3,
    parameter int DEB_CNT = 50000,
    parameter int REP_DLY = 25000000,
    parameter int REP_PER = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    btn_cond_if.slave  bus
);

    localparam int            DW       = $clog2(DEB_CNT);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

    generate
        if (DEB_CNT < 2 || REP_DLY < 2 || REP_PER < 2) begin : g_bad_param
            $error("btn_cond: DEB_CNT, REP_DLY and REP_PER must all be >= 2");
        end
    endgenerate

    logic [N-1:0]  sync1_q, sync1_d;
    logic [N-1:0]  sync2_q, sync2_d;
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  press_q, press_d;
    logic [N-1:0]  release_q, release_d;
    logic [DW-1:0] deb_cnt_q [N];
    logic [DW-1:0] deb_cnt_d [N];
    logic [N-1:0]  pressed;

`ifdef BTN_REPEAT_EN
    localparam int            REP_MAX  = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int            RW       = $clog2(REP_MAX);
    localparam logic [RW-1:0] DLY_LAST = RW'(REP_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REP_PER - 1);

    logic [RW-1:0] rep_cnt_q [N];
    logic [RW-1:0] rep_cnt_d [N];
    logic [N-1:0]  rep_run_q, rep_run_d;
`endif

    // Buttons are active-low; the second synchronizer stage is the only raw-input consumer.
    assign pressed = ~sync2_q;

    always_comb begin
        sync1_d   = bus.btn_i;
        sync2_d   = sync1_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        deb_cnt_d = deb_cnt_q;
`ifdef BTN_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
        rep_run_d = rep_run_q;
`endif
        for (int i = 0; i < N; i++) begin
            if (pressed[i] == level_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                level_d[i]   = ~level_q[i];
                deb_cnt_d[i] = '0;
                press_d[i]   = ~level_q[i];
                release_d[i] = level_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
`ifdef BTN_REPEAT_EN
            // Repeat timing only runs while the level stays high across this edge;
            // the accepted press and any fall both restart it from zero.
            if (!level_q[i] || !level_d[i]) begin
                rep_cnt_d[i] = '0;
                rep_run_d[i] = 1'b0;
            end else if (rep_cnt_q[i] == (rep_run_q[i] ? PER_LAST : DLY_LAST)) begin
                rep_cnt_d[i] = '0;
                rep_run_d[i] = 1'b1;
                press_d[i]   = 1'b1;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + RW'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            deb_cnt_q <= '{default: '0};
`ifdef BTN_REPEAT_EN
            rep_cnt_q <= '{default: '0};
            rep_run_q <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            deb_cnt_q <= deb_cnt_d;
`ifdef BTN_REPEAT_EN
            rep_cnt_q <= rep_cnt_d;
            rep_run_q <= rep_run_d;
`endif
        end
    end

    assign bus.level_o   = level_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;

endmodule

// File: doc/btn_cond.md
BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the number of independent button channels.
REQ-002 The block SHALL have parameter DEB_CNT, default 50000, meaning consecutive stable cycles required to accept a level change; legal range is DEB_CNT >= 2.
REQ-003 The block SHALL have parameter REP_DLY, default 25000000, meaning cycles from press to first auto-repeat; REP_DLY >= 2.
REQ-004 The block SHALL have parameter REP_PER, default 5000000, meaning cycles between auto-repeats; REP_PER >= 2.
REQ-005 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 Port rst: input, 1 bit, synchronous active-high reset.
REQ-007 Port btn: input, N bits, raw asynchronous buttons, active-low (0 = pressed).
REQ-008 Port level: output, N bits, debounced pressed state, active-high.
REQ-009 Port press: output, N bits, one-cycle active-high pulse per accepted press (and per repeat when enabled).
REQ-010 Port release: output, N bits, one-cycle active-high pulse per accepted release.

Function
REQ-011 Each btn bit SHALL pass through a two-flop synchronizer before any other logic; the second flop's output, inverted, is the sampled "pressed" value.
REQ-012 Each channel SHALL keep a debounce counter of width clog2(DEB_CNT): reset to 0 on any cycle where sampled value equals level; incremented on each cycle where it differs.
REQ-013 When the counter equals DEB_CNT-1 and sampled still differs from level, level SHALL toggle at that edge and the counter SHALL clear.
REQ-014 press[i] SHALL be registered at the same edge level[i] rises 0->1; release[i] SHALL be registered at the same edge level[i] falls 1->0; each is high for exactly one cycle.
REQ-015 Latency: counting the first edge sampling the new btn value as edge 0, level/press/release SHALL update at edge DEB_CNT+1.
REQ-016 Any bounce shorter than DEB_CNT consecutive sampled cycles SHALL leave level unchanged and produce no pulse.
REQ-017 Channels SHALL be fully independent; any combination of press/release bits MAY be high in the same cycle.
REQ-018 Counters SHALL saturate logically via REQ-013; no counter SHALL wrap while a mismatch persists.
REQ-019 press and release for one channel SHALL never be high in the same cycle.

Reset
REQ-020 While rst is high at an edge: synchronizer flops SHALL load 1 (released), level, press, release SHALL load 0, and all debounce and repeat counters SHALL load 0.
REQ-021 A button held through reset release SHALL be reported as a fresh press after the full REQ-015 latency measured from the first post-reset edge.
REQ-022 Reset asserted mid-debounce SHALL discard partial count; no pulse is emitted for the interrupted change.

Configuration
REQ-023 With macro BTN_REPEAT_EN defined, each channel SHALL hold a repeat counter: cleared on the accepted press, and on reaching REP_DLY-1 cycles of continued level=1 it SHALL emit a press pulse; thereafter it SHALL emit a press pulse every REP_PER cycles until level falls.
REQ-024 With BTN_REPEAT_EN defined, level falling SHALL clear the repeat counter immediately, with no further repeat pulses.
REQ-025 Without BTN_REPEAT_EN, no repeat logic SHALL be synthesized and press SHALL pulse exactly once per accepted press.

Verification (DEB_CNT=4, REP_DLY=10, REP_PER=3, N=3)
REQ-026 btn[1] driven low from edge 0 and held 20 cycles -> press[1] high only in the cycle after edge 5, level[1]=1 from edge 5; release, press[0], and press[2] stay 0.
REQ-027 btn[0] low 3 cycles, high 1, low 3, then high -> level[0] stays 0 and no pulse on press[0] or release[0].
REQ-028 From level[2]=1, btn[2] driven high at edge 0 -> release[2] one pulse at edge 5, level[2]=0 from edge 5.
REQ-029 All btn driven low at the same edge 0 -> press=3'b111 for exactly one cycle at edge 5.
REQ-030 btn[0] low, rst pulsed for one cycle at edge 3 -> no pulse at edge 5; press[0] at the 6th edge after rst deasserts.
REQ-031 btn[0] held low 30 cycles: with BTN_REPEAT_EN -> press[0] pulses at edges 5, 15, 18, 21, 24, 27, 30; without -> only at edge 5.
